// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: redirect/stall control, instruction-memory port,
// and the IF/ID register outputs.
//   master : the fetch stage (drives imem_pc and all if_id_* / status outputs)
//   slave  : the surrounding pipeline and instruction memory
interface fetch_stage_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_target;
    logic [PC_W-1:0]  imem_pc;
    logic [31:0]      imem_instr;
    logic [31:0]      if_id_instr;
    logic [PC_W-1:0]  if_id_pc;
    logic [PC_W-1:0]  if_id_pc_plus4;
    logic             if_id_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instr,
        output imem_pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
               misalign_err, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instr,
        input  imem_pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
               misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the PC, addresses a synchronous
// instruction memory (data returns one clock after the address), pairs each
// returned word with its fetch address and registers the pair into IF/ID.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master -- stall / redirect in, imem address out,
//              imem data in, IF/ID outputs, misalign pulse, delivered count
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_WORD = 32'h0000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);
    // pc: next address to fetch; f_pc/f_valid: address whose word is on
    // imem_instr this cycle and whether that word is usable.
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  f_pc_q, f_pc_d;
    logic             f_valid_q, f_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [PC_W-1:0]  id_pc_q, id_pc_d;
    logic [PC_W-1:0]  id_pc4_q, id_pc4_d;
    logic             id_valid_q, id_valid_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // While stalled, re-present the in-flight address so the memory output
    // still matches f_pc when the stall releases.
    assign bus.imem_pc = bus.stall ? f_pc_q : pc_q;

    always_comb begin
        pc_d       = pc_q;
        f_pc_d     = f_pc_q;
        f_valid_d  = f_valid_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;

        if (bus.redirect_valid) begin
            // Flush: drop the in-flight word and the IF/ID contents; the
            // IF/ID address fields keep their last values.
            pc_d       = {bus.redirect_target[PC_W-1:2], 2'b00};
            f_valid_d  = 1'b0;
            instr_d    = NOP_WORD;
            id_valid_d = 1'b0;
            misalign_d = |bus.redirect_target[1:0];
        end else if (!bus.stall) begin
            f_pc_d     = pc_q;
            f_valid_d  = 1'b1;
            pc_d       = pc_q + PC_W'(4);
            instr_d    = f_valid_q ? bus.imem_instr : NOP_WORD;
            id_pc_d    = f_pc_q;
            id_pc4_d   = f_pc_q + PC_W'(4);
            id_valid_d = f_valid_q;
            if (f_valid_q) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            f_pc_q     <= RESET_PC;
            f_valid_q  <= 1'b0;
            instr_q    <= NOP_WORD;
            id_pc_q    <= '0;
            id_pc4_q   <= PC_W'(4);
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            f_pc_q     <= f_pc_d;
            f_valid_q  <= f_valid_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc       = id_pc_q;
    assign bus.if_id_pc_plus4 = id_pc4_q;
    assign bus.if_id_valid    = id_valid_q;
    assign bus.misalign_err   = misalign_q;
    assign bus.fetch_count    = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized reset/stall/redirect traffic against a latency-based model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk, rst;
    fetch_stage_if #(.PC_W(8), .CNT_W(16)) bus();

    fetch_stage #(.PC_W(8), .RESET_PC(8'h00), .NOP_WORD(NOP), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory, big-endian words, address wraps at 256.
    logic [7:0] mem [256];

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    always @(posedge clk) bus.imem_instr <= word_at(bus.imem_pc);

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_addr is the next address to be delivered into IF/ID;
    // m_warm is the number of unstalled edges until it is delivered (2 after a
    // reset or redirect, then 1 forever while streaming).
    logic [7:0]  m_addr;
    int          m_warm = 0;
    logic        m_valid, m_pc_known, m_mis;
    logic [31:0] m_instr;
    logic [7:0]  m_pc, m_pc4;
    logic [15:0] m_cnt;

    task automatic model(input logic r, s, rv, input logic [7:0] t);
        if (r) begin
            m_addr = 8'h00; m_warm = 2; m_valid = 0; m_instr = NOP;
            m_pc = 8'h00; m_pc4 = 8'h04; m_pc_known = 1; m_mis = 0; m_cnt = 0;
        end else begin
            m_mis = 0;
            if (rv) begin
                m_addr = t & 8'hFC; m_warm = 2; m_valid = 0; m_instr = NOP;
                m_mis = |t[1:0];
            end else if (!s) begin
                if (m_warm > 1) begin
                    m_warm--; m_valid = 0; m_instr = NOP; m_pc_known = 0;
                end else begin
                    m_valid = 1; m_instr = word_at(m_addr);
                    m_pc = m_addr; m_pc4 = m_addr + 8'd4; m_pc_known = 1;
                    m_addr = m_addr + 8'd4;
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    endtask

    task automatic check_out();
        chk("valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
        chk("instr", bus.if_id_instr, m_instr);
        if (m_pc_known) begin
            chk("pc", {24'd0, bus.if_id_pc}, {24'd0, m_pc});
            chk("pc_plus4", {24'd0, bus.if_id_pc_plus4}, {24'd0, m_pc4});
        end
        chk("misalign", {31'd0, bus.misalign_err}, {31'd0, m_mis});
        chk("count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
    endtask

    // One clock: drive at the falling edge, check imem_pc, update model at
    // the rising edge, check registered outputs at the next falling edge.
    task automatic step(input logic r, s, rv, input logic [7:0] t);
        logic [7:0] nxt;
        rst = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = t;
        #1;
        if (!r) begin
            nxt = m_addr + 8'd4;
            if (m_warm == 1)
                chk("imem_pc", {24'd0, bus.imem_pc}, {24'd0, (s ? m_addr : nxt)});
            else if (m_warm == 2 && !s)
                chk("imem_pc", {24'd0, bus.imem_pc}, {24'd0, m_addr});
        end
        @(posedge clk);
        model(r, s, rv, t);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {mem[0], mem[1], mem[2],  mem[3]}  = 32'h1111_1111;
        {mem[4], mem[5], mem[6],  mem[7]}  = 32'h2222_2222;
        {mem[8], mem[9], mem[10], mem[11]} = 32'h3333_3333;
        rst = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 8'h00;

        // Reset, then free-run three instructions.
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);
        chk("count_after_3", {16'd0, bus.fetch_count}, 32'd3);

        // Stall for 3 cycles while IF/ID holds pc 4, then release.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
        chk("stall_at_pc4", {24'd0, bus.if_id_pc}, 32'h4);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("after_stall_pc8", {24'd0, bus.if_id_pc}, 32'h8);
        chk("after_stall_w8", bus.if_id_instr, 32'h3333_3333);

        // Redirect to 0x40 while IF/ID holds pc 8.
        step(0, 0, 1, 8'h40);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("redir_pc40", {24'd0, bus.if_id_pc}, 32'h40);
        chk("redir_pc44", {24'd0, bus.if_id_pc_plus4}, 32'h44);

        // Redirect + stall with a misaligned target: redirect wins.
        step(0, 1, 1, 8'h21);
        chk("mis_pulse", {31'd0, bus.misalign_err}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);

        // Wrap from 0xF8 through 0xFC to 0x00.
        step(0, 0, 1, 8'hF8);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);

        // Reset during a stalled redirect discards everything.
        step(0, 0, 1, 8'h80);
        step(1, 1, 1, 8'h33);
        chk("rst_count", {16'd0, bus.fetch_count}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) == 0, $urandom_range(3) == 0,
                 $urandom_range(7) == 0, 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
